// File: rtl/bus_xfer_ctrl_if.sv
// Core-side request/response handshake plus the bus-stage control lines
// driven by bus_xfer_ctrl.
interface bus_xfer_ctrl_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_write;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_wdata;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [DATA_WIDTH-1:0] rsp_rdata;
  logic                  rsp_err;
  logic                  bus_ale_en;
  logic                  bus_write_en;
  logic                  bus_read_en;
  logic [ADDR_WIDTH-1:0] bus_addr_out;
  logic [DATA_WIDTH-1:0] bus_wdata_out;
  logic [DATA_WIDTH-1:0] bus_rdata_in;
  logic                  mem_ack;

  // Controller side.
  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, rsp_ready,
           bus_rdata_in, mem_ack,
    output req_ready, rsp_valid, rsp_rdata, rsp_err,
           bus_ale_en, bus_write_en, bus_read_en, bus_addr_out, bus_wdata_out
  );

  // Requester / memory side.
  modport master (
    output req_valid, req_write, req_addr, req_wdata, rsp_ready,
           bus_rdata_in, mem_ack,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err,
           bus_ale_en, bus_write_en, bus_read_en, bus_addr_out, bus_wdata_out
  );
endinterface

// File: rtl/bus_xfer_ctrl.sv
// Single-outstanding bus transfer sequencer: ALE -> (WDATA) -> WAIT with a
// bounded ack timeout -> one response to the requester.
module bus_xfer_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8,
  parameter int TIMEOUT    = 15
) (
  input  logic               clk,
  input  logic               rst,
  bus_xfer_ctrl_if.slave     bus
);
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ALE   = 3'd1,
    S_WDATA = 3'd2,
    S_WAIT  = 3'd3,
    S_RESP  = 3'd4
  } state_t;

  state_t                r_state;
  logic                  r_is_write;
  logic [CNT_W-1:0]      r_wait_cnt;
  logic                  r_ale_en;
  logic                  r_write_en;
  logic                  r_read_en;
  logic                  r_rsp_valid;
  logic                  r_rsp_err;
  logic [DATA_WIDTH-1:0] r_rsp_rdata;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic                  w_timeout;

  assign w_timeout = (r_wait_cnt == CNT_LAST);

  // Enables are registered alongside the state so each one mirrors exactly
  // the state being entered.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_is_write  <= 1'b0;
      r_wait_cnt  <= '0;
      r_ale_en    <= 1'b0;
      r_write_en  <= 1'b0;
      r_read_en   <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_err   <= 1'b0;
      r_rsp_rdata <= '0;
      r_addr      <= '0;
      r_wdata     <= '0;
    end else begin
      r_ale_en   <= 1'b0;
      r_write_en <= 1'b0;
      r_read_en  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.req_valid) begin
            r_addr     <= bus.req_addr;
            r_wdata    <= bus.req_write ? bus.req_wdata : '0;
            r_is_write <= bus.req_write;
            r_ale_en   <= 1'b1;
            r_state    <= S_ALE;
          end
        end
        S_ALE: begin
          r_wait_cnt <= '0;
          if (r_is_write) begin
            r_write_en <= 1'b1;
            r_state    <= S_WDATA;
          end else begin
            r_read_en <= 1'b1;
            r_state   <= S_WAIT;
          end
        end
        S_WDATA: begin
          r_wait_cnt <= '0;
          r_read_en  <= 1'b1;
          r_state    <= S_WAIT;
        end
        S_WAIT: begin
          if (bus.mem_ack) begin
            r_rsp_valid <= 1'b1;
            r_rsp_err   <= 1'b0;
            r_rsp_rdata <= r_is_write ? '0 : bus.bus_rdata_in;
            r_state     <= S_RESP;
          end else begin
            // Width holds TIMEOUT, so the final increment cannot wrap.
            r_wait_cnt <= r_wait_cnt + CNT_W'(1);
            if (w_timeout) begin
              r_rsp_valid <= 1'b1;
              r_rsp_err   <= 1'b1;
              r_rsp_rdata <= '0;
              r_state     <= S_RESP;
            end else begin
              r_read_en <= 1'b1;
            end
          end
        end
        S_RESP: begin
          if (bus.rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: begin
          r_rsp_valid <= 1'b0;
          r_state     <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.req_ready     = (r_state == S_IDLE) && !rst;
  assign bus.rsp_valid     = r_rsp_valid;
  assign bus.rsp_err       = r_rsp_err;
  assign bus.rsp_rdata     = r_rsp_rdata;
  assign bus.bus_ale_en    = r_ale_en;
  assign bus.bus_write_en  = r_write_en;
  assign bus.bus_read_en   = r_read_en;
  assign bus.bus_addr_out  = r_addr;
  assign bus.bus_wdata_out = r_wdata;
endmodule

// File: tb/tb_bus_xfer_ctrl.sv
// Self-checking bench for bus_xfer_ctrl: directed scenarios plus random
// transfers checked against a latency/response model of the controller.
module tb_bus_xfer_ctrl;
  localparam int DW = 32;
  localparam int AW = 8;
  localparam int T  = 15;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  bus_xfer_ctrl_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus_if ();

  bus_xfer_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TIMEOUT(T)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [4:0] ctl_vec();
    return {bus_if.bus_ale_en, bus_if.bus_write_en, bus_if.bus_read_en,
            bus_if.rsp_valid, bus_if.req_ready};
  endfunction

  // One transfer from an IDLE cycle through the response handshake.
  // ack_at: 1-based WAIT cycle carrying mem_ack (0 or >T = never).
  task automatic run_xfer(input bit wr, input logic [AW-1:0] addr,
                          input logic [DW-1:0] wdata, input logic [DW-1:0] rdata,
                          input int ack_at, input int bp, input bit stray,
                          input string tag);
    int            n_wait;
    bit            exp_err;
    logic [DW-1:0] exp_rdata;
    logic [DW-1:0] exp_wdata;
    logic [4:0]    v;
    exp_err   = !(ack_at >= 1 && ack_at <= T);
    n_wait    = exp_err ? T : ack_at;
    exp_rdata = (exp_err || wr) ? '0 : rdata;
    exp_wdata = wr ? wdata : '0;

    n_tests++;
    if (bus_if.req_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL %s idle_ready got=%b want=1", tag, bus_if.req_ready);
    end
    bus_if.req_valid = 1'b1;
    bus_if.req_write = wr;
    bus_if.req_addr  = addr;
    bus_if.req_wdata = wdata;
    bus_if.mem_ack   = stray;
    tick();
    // Cycle 1: ALE; further requests must be ignored from here on.
    bus_if.req_valid = 1'b1;
    bus_if.req_write = 1'($urandom);
    bus_if.req_addr  = AW'($urandom);
    bus_if.req_wdata = $urandom;
    bus_if.mem_ack   = stray;
    v = ctl_vec();
    n_tests++;
    if (v !== 5'b10000 || bus_if.bus_addr_out !== addr || bus_if.bus_wdata_out !== exp_wdata) begin
      n_fail++;
      $display("FAIL %s ale got ctl=%b addr=%h wd=%h want ctl=10000 addr=%h wd=%h",
               tag, v, bus_if.bus_addr_out, bus_if.bus_wdata_out, addr, exp_wdata);
    end
    if (wr) begin
      tick();
      bus_if.mem_ack = 1'($urandom);
      v = ctl_vec();
      n_tests++;
      if (v !== 5'b01000 || bus_if.bus_wdata_out !== exp_wdata) begin
        n_fail++;
        $display("FAIL %s wdata got ctl=%b wd=%h want ctl=01000 wd=%h",
                 tag, v, bus_if.bus_wdata_out, exp_wdata);
      end
    end
    for (int w = 1; w <= n_wait; w++) begin
      tick();
      bus_if.mem_ack      = (w == ack_at);
      bus_if.bus_rdata_in = (w == ack_at) ? rdata : $urandom;
      v = ctl_vec();
      n_tests++;
      if (v !== 5'b00100 || bus_if.bus_addr_out !== addr || bus_if.bus_wdata_out !== exp_wdata) begin
        n_fail++;
        $display("FAIL %s wait%0d got ctl=%b addr=%h wd=%h want ctl=00100 addr=%h wd=%h",
                 tag, w, v, bus_if.bus_addr_out, bus_if.bus_wdata_out, addr, exp_wdata);
      end
    end
    tick();
    bus_if.mem_ack      = 1'($urandom);
    bus_if.bus_rdata_in = $urandom;
    if (bp > 0) bus_if.rsp_ready = 1'b0;
    v = ctl_vec();
    n_tests++;
    if (v !== 5'b00010 || bus_if.rsp_err !== exp_err || bus_if.rsp_rdata !== exp_rdata
        || bus_if.bus_addr_out !== addr) begin
      n_fail++;
      $display("FAIL %s resp got ctl=%b err=%b rd=%h want ctl=00010 err=%b rd=%h",
               tag, v, bus_if.rsp_err, bus_if.rsp_rdata, exp_err, exp_rdata);
    end
    for (int i = 0; i < bp; i++) begin
      tick();
      bus_if.req_valid = 1'b1;
      bus_if.mem_ack   = 1'($urandom);
      v = ctl_vec();
      n_tests++;
      if (v !== 5'b00010 || bus_if.rsp_err !== exp_err || bus_if.rsp_rdata !== exp_rdata) begin
        n_fail++;
        $display("FAIL %s hold%0d got ctl=%b err=%b rd=%h want ctl=00010 err=%b rd=%h",
                 tag, i, v, bus_if.rsp_err, bus_if.rsp_rdata, exp_err, exp_rdata);
      end
    end
    bus_if.rsp_ready = 1'b1;
    tick();
    bus_if.req_valid = 1'b0;
    bus_if.mem_ack   = 1'b0;
    v = ctl_vec();
    n_tests++;
    if (v !== 5'b00001 || bus_if.rsp_err !== exp_err || bus_if.rsp_rdata !== exp_rdata) begin
      n_fail++;
      $display("FAIL %s post_hs got ctl=%b err=%b rd=%h want ctl=00001 err=%b rd=%h",
               tag, v, bus_if.rsp_err, bus_if.rsp_rdata, exp_err, exp_rdata);
    end
    $display("[TB] %s wr=%0d addr=%h ack_at=%0d waits=%0d bp=%0d err=%0d rdata=%h",
             tag, wr, addr, ack_at, n_wait, bp, exp_err, exp_rdata);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    tick();
    tick();
    n_tests++;
    if (ctl_vec() !== 5'b00000 || bus_if.bus_addr_out !== '0 || bus_if.bus_wdata_out !== '0
        || bus_if.rsp_rdata !== '0 || bus_if.rsp_err !== 1'b0) begin
      n_fail++;
      $display("FAIL reset got ctl=%b addr=%h wd=%h rd=%h err=%b want all 0",
               ctl_vec(), bus_if.bus_addr_out, bus_if.bus_wdata_out,
               bus_if.rsp_rdata, bus_if.rsp_err);
    end
    rst = 1'b0;
    #1;
    $display("[TB] reset checked");
  endtask

  task automatic test_write;
    run_xfer(1'b1, 8'h3C, 32'hDEADBEEF, 32'hA5A5A5A5, 1, 0, 1'b0, "write");
  endtask

  task automatic test_read;
    run_xfer(1'b0, 8'h05, 32'h0, 32'h12345678, 3, 0, 1'b0, "read");
  endtask

  task automatic test_timeout;
    run_xfer(1'b0, 8'h77, 32'h0, 32'hCAFEF00D, 0,  0, 1'b0, "timeout");
    run_xfer(1'b0, 8'h78, 32'h0, 32'h0BADC0DE, T,  0, 1'b0, "ack_at_limit");
    run_xfer(1'b1, 8'h79, 32'h11112222, 32'h0, 0,  0, 1'b0, "wr_timeout");
  endtask

  task automatic test_backpressure;
    run_xfer(1'b0, 8'h9A, 32'h0, 32'h55AA33CC, 2, 5, 1'b1, "backpressure");
  endtask

  task automatic test_reset_mid;
    bus_if.req_valid = 1'b1;
    bus_if.req_write = 1'b1;
    bus_if.req_addr  = 8'hE1;
    bus_if.req_wdata = 32'hFEEDFACE;
    tick();
    bus_if.req_valid = 1'b0;
    tick();
    n_tests++;
    if (ctl_vec() !== 5'b01000) begin
      n_fail++;
      $display("FAIL rst_mid wdata got ctl=%b want 01000", ctl_vec());
    end
    rst = 1'b1;
    tick();
    n_tests++;
    if (ctl_vec() !== 5'b00000 || bus_if.bus_addr_out !== '0 || bus_if.bus_wdata_out !== '0
        || bus_if.rsp_rdata !== '0 || bus_if.rsp_err !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_mid cleared got ctl=%b addr=%h wd=%h rd=%h err=%b want all 0",
               ctl_vec(), bus_if.bus_addr_out, bus_if.bus_wdata_out,
               bus_if.rsp_rdata, bus_if.rsp_err);
    end
    rst = 1'b0;
    #1;
    for (int i = 0; i < 4; i++) begin
      bus_if.mem_ack = 1'b1;
      n_tests++;
      if (ctl_vec() !== 5'b00001) begin
        n_fail++;
        $display("FAIL rst_mid idle%0d got ctl=%b want 00001", i, ctl_vec());
      end
      tick();
    end
    bus_if.mem_ack = 1'b0;
    $display("[TB] reset during WDATA checked");
  endtask

  task automatic test_back_to_back;
    bus_if.rsp_ready = 1'b1;
    run_xfer(1'b1, 8'h10, 32'h01020304, 32'h0, 1, 0, 1'b1, "b2b_0");
    run_xfer(1'b1, 8'h11, 32'hA0B0C0D0, 32'h0, 1, 0, 1'b1, "b2b_1");
  endtask

  task automatic test_random;
    for (int i = 0; i < 20; i++) begin
      run_xfer(1'($urandom), AW'($urandom), $urandom, $urandom,
               int'($urandom_range(0, T + 1)), int'($urandom_range(0, 3)),
               1'($urandom), "random");
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    bus_if.req_valid    = 1'b0;
    bus_if.req_write    = 1'b0;
    bus_if.req_addr     = '0;
    bus_if.req_wdata    = '0;
    bus_if.rsp_ready    = 1'b0;
    bus_if.bus_rdata_in = '0;
    bus_if.mem_ack      = 1'b0;
    test_reset();
    test_write();
    test_read();
    test_timeout();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
